// File: rtl/tc_sram_stream.sv
// Multi-port functional SRAM with request/grant issue, credit-based flow control and a
// per-port valid/ready response FIFO. Define TC_SRAM_STREAM_WFWD_EN for write-first reads.
module tc_sram_stream #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 2,
  parameter string       SimInit   = "none",
  localparam int unsigned AW = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BW = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumPorts-1:0]                  req_i,
  output logic [NumPorts-1:0]                  gnt_o,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][AW-1:0]          addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][BW-1:0]          be_i,
  output logic [NumPorts-1:0]                  rvalid_o,
  input  logic [NumPorts-1:0]                  rready_i,
  output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
);

  localparam int unsigned CW = $clog2(RspDepth + 1);
  localparam int unsigned PW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam logic [AW:0] WordLimit = (AW + 1)'(NumWords);
  // "random" and "none" both start undefined; the simulator's X policy decides the values.
  localparam logic [DataWidth-1:0] InitWord =
    (SimInit == "ones")  ? {DataWidth{1'b1}} :
    (SimInit == "zeros") ? {DataWidth{1'b0}} : {DataWidth{1'bx}};

  if (NumWords < 1) begin : g_bad_words
    $fatal(1, "tc_sram_stream: NumWords must be >= 1");
  end
  if (Latency < 1) begin : g_bad_latency
    $fatal(1, "tc_sram_stream: Latency must be >= 1");
  end
  if (RspDepth < 1) begin : g_bad_depth
    $fatal(1, "tc_sram_stream: RspDepth must be >= 1");
  end

  function automatic logic [DataWidth-1:0] lane_mask(input logic [BW-1:0] be);
    logic [DataWidth-1:0] m;
    for (int b = 0; b < int'(DataWidth); b++) m[b] = be[b / int'(ByteWidth)];
    return m;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < WordLimit;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(RspDepth - 1)) ? '0 : ptr + PW'(1);
  endfunction

  function automatic logic [CW-1:0] next_credit(input logic [CW-1:0] c, input logic take,
                                                input logic give);
    if (take && !give) return c - CW'(1);
    if (give && !take) return c + CW'(1);
    return c;
  endfunction

  logic [DataWidth-1:0] mem [NumWords] = '{default: InitWord};

  logic [NumPorts-1:0]                wr_fire, rd_fire, addr_ok, pop, push_vld;
  logic [NumPorts-1:0][DataWidth-1:0] wmask, old_word, merged_word, rd_word, push_dat;
  logic [NumPorts-1:0][CW-1:0]        credits, count;
  logic [NumPorts-1:0][PW-1:0]        wr_ptr, rd_ptr;
  logic [DataWidth-1:0]               fifo_q [NumPorts][RspDepth];

  // Issue: grant, write-lane merge and array read for every port.
  always_comb begin
    gnt_o       = '0;
    wr_fire     = '0;
    rd_fire     = '0;
    addr_ok     = '0;
    wmask       = '0;
    old_word    = '0;
    merged_word = '0;
    rd_word     = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      addr_ok[p] = in_range(addr_i[p]);
      wmask[p]   = lane_mask(be_i[p]);
      gnt_o[p]   = !rst_i && req_i[p] && (we_i[p] || credits[p] != '0);
      wr_fire[p] = gnt_o[p] && we_i[p];
      rd_fire[p] = gnt_o[p] && !we_i[p];
    end
    for (int p = 0; p < int'(NumPorts); p++) begin
      old_word[p]    = addr_ok[p] ? mem[addr_i[p]] : '0;
      merged_word[p] = old_word[p];
      // Lower-index ports are applied last so they own any contested lane.
      for (int q = int'(NumPorts) - 1; q >= 0; q--) begin
        if (addr_ok[p] && wr_fire[q] && addr_ok[q] && addr_i[q] == addr_i[p])
          merged_word[p] = (merged_word[p] & ~wmask[q]) | (wdata_i[q] & wmask[q]);
      end
`ifdef TC_SRAM_STREAM_WFWD_EN
      rd_word[p] = merged_word[p];
`else
      rd_word[p] = old_word[p];
`endif
    end
  end

  // Every port writing one word computes the same merged value, so write order is irrelevant.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < int'(NumPorts); p++) begin
      if (wr_fire[p] && addr_ok[p]) mem[addr_i[p]] <= merged_word[p];
    end
  end

  if (Latency == 1) begin : g_lat1
    assign push_vld = rd_fire;
    assign push_dat = rd_word;
  end else begin : g_pipe
    logic [NumPorts-1:0]                vld_p [Latency-1];
    logic [NumPorts-1:0][DataWidth-1:0] dat_p [Latency-1];

    // Read pipeline stages p0 .. p(Latency-2) between array and response FIFO.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s < int'(Latency) - 1; s++) vld_p[s] <= '0;
      end else begin
        vld_p[0] <= rd_fire;
        for (int s = 1; s < int'(Latency) - 1; s++) vld_p[s] <= vld_p[s-1];
      end
    end

    always_ff @(posedge clk_i) begin
      dat_p[0] <= rd_word;
      for (int s = 1; s < int'(Latency) - 1; s++) dat_p[s] <= dat_p[s-1];
    end

    assign push_vld = vld_p[Latency-2];
    assign push_dat = dat_p[Latency-2];
  end

  // Response FIFO output; data is forced to zero whenever nothing is buffered.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    pop      = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      rvalid_o[p] = count[p] != '0;
      rdata_o[p]  = rvalid_o[p] ? fifo_q[p][rd_ptr[p]] : '0;
      pop[p]      = rvalid_o[p] && rready_i[p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        credits[p] <= CW'(RspDepth);
        count[p]   <= '0;
        wr_ptr[p]  <= '0;
        rd_ptr[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        credits[p] <= next_credit(credits[p], rd_fire[p], pop[p]);
        count[p]   <= next_credit(count[p], pop[p], push_vld[p]);
        if (push_vld[p]) wr_ptr[p] <= next_ptr(wr_ptr[p]);
        if (pop[p])      rd_ptr[p] <= next_ptr(rd_ptr[p]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < int'(NumPorts); p++) begin
      if (push_vld[p]) fifo_q[p][wr_ptr[p]] <= push_dat[p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        if (gnt_o[p])
          assert (addr_ok[p])
          else $warning("tc_sram_stream: port %0d address %0d is out of range", p, addr_i[p]);
        assert (!(push_vld[p] && !pop[p] && count[p] == CW'(RspDepth)))
        else $error("tc_sram_stream: port %0d response buffer overflow", p);
      end
    end
  end

endmodule

// File: doc/tc_sram_stream.md
Name: tc_sram_stream

Overview:
Multi-port, multi-latency functional SRAM with a request/grant handshake and a valid/ready read-response channel on every port. Each port has its own response buffer, so read data is held until the consumer accepts it. It is the stall-capable successor of the fixed-latency tc_sram. It sits in the technology-cell layer and serves interconnects that cannot guarantee to sink read data in a fixed cycle.

Parameters:
NumWords, 1024, number of words; must be >= 1
DataWidth, 64, word width in bits
ByteWidth, 8, bits per byte-enable lane
NumPorts, 2, number of independent read/write ports
Latency, 1, cycles from a granted read to the data entering the response buffer; must be >= 1
RspDepth, 2, per-port response buffer entries; must be >= 1; full throughput needs RspDepth >= Latency+1
SimInit, "none", initial array content: "zeros", "ones", "random" or "none" (X)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous active-high reset
req_i  in  NumPorts  per-port request
gnt_o  out  NumPorts  per-port grant; combinational from req_i and credit state
we_i  in  NumPorts  1 = write, 0 = read
addr_i  in  NumPorts x AW  word address; AW = max(1, $clog2(NumWords))
wdata_i  in  NumPorts x DataWidth  write data
be_i  in  NumPorts x BW  byte enables; BW = ceil(DataWidth/ByteWidth)
rvalid_o  out  NumPorts  response valid
rready_i  in  NumPorts  response ready
rdata_o  out  NumPorts x DataWidth  response data; stable while rvalid_o && !rready_i

Behaviour:
- Reset (rst_i=1 at an edge): credits[p] = RspDepth; all pipeline stages and buffers are emptied; rvalid_o = 0, rdata_o = 0.
  - Array content is NOT reset.
  - In-flight reads are discarded; no response is ever produced for them.
  - gnt_o = 0 while rst_i = 1.
- Per-port credit counter, width $clog2(RspDepth+1):
  - Decrements on a granted read; increments on a response pop (rvalid_o && rready_i).
  - Both in the same cycle: value unchanged.
  - Never exceeds RspDepth; never drops below 0.
- Grant rules:
  - Write: gnt_o[p] = req_i[p] (writes are always accepted).
  - Read: gnt_o[p] = req_i[p] && (credits[p] > 0).
  - A request with gnt_o = 0 has no effect; the master holds it until granted.
- Write: at the edge with req && gnt && we, each lane with be set is updated; other lanes are unchanged. be = 0 is a legal no-op.
- Write collision: several ports write the same word in one cycle → per byte lane, the lowest-index enabled port wins.
- Read: the array is sampled at the grant edge, read-first across ports. A same-cycle write to the same address from any port does not affect the read data.
- Read pipeline: data moves through Latency-1 register stages, then enters the port FIFO.
  - Latency=1: rvalid_o rises in the cycle after the grant when the FIFO was empty.
- Response FIFO: depth RspDepth, in order.
  - rvalid_o = FIFO not empty; rdata_o = head entry.
  - Push and pop in the same cycle are both allowed.
  - The FIFO cannot overflow because of credits; overflow is a simulation assertion.
- Out-of-range address (addr >= NumWords):
  - Write: ignored.
  - Read: granted normally, returns all zeros.
  - Either case raises a simulation $warning.
- Invalid parameters (Latency=0, RspDepth=0, NumWords=0) → $fatal at elaboration.

Optional Feature:
TC_SRAM_STREAM_WFWD_EN
- Defined: reads are write-first. A read and a same-cycle write to the same address return the post-write word, including lowest-index-wins lane merging across ports.
- Undefined: read-first, as described in Behaviour. No other difference; port list and latency are identical.

Test Plan:
- Reset then idle, SimInit="zeros" → rvalid_o=0, rdata_o=0, gnt_o=0 during reset; gnt_o=1 for any write request after reset.
- Port 0 writes 0x1122334455667788 to addr 5 with be=0xFF, then with be=0x0F writes 0xAAAAAAAAAAAAAAAA; read addr 5 with Latency=1, rready=1 → rvalid_o one cycle after grant, rdata_o=0x11223344AAAAAAAA.
- Latency=3, RspDepth=2, rready_i=0, back-to-back reads on port 1 → exactly 2 grants, then gnt_o=0. Raise rready_i for one cycle → 1 pop, 1 new grant; responses arrive in issue order.
- Ports 0 and 1 write addr 7 in the same cycle, be 0xFF vs 0x0F, data 0x00…00 vs 0xFF…FF → memory = 0x0000000000000000 (port 0 wins all lanes).
- Port 0 reads addr 3 (old value 0x1) while port 1 writes 0x2 to it in the same cycle → response 0x1; 0x2 with TC_SRAM_STREAM_WFWD_EN.
- Assert rst_i with 2 reads in flight and 1 buffered → no rvalid_o afterwards; credits back to RspDepth; a new read completes normally.
